// File: rtl/cr_job_initiator.sv
// Initiator end of the start/done operand protocol: takes a job, drives start and the
// operands to the responder, waits for done with a timeout and hands CR downstream.
// Optional result checker enabled by defining CR_JOB_CHECK_EN.
module cr_job_initiator #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [WIDTH-1:0] job_ar,
  input  logic [WIDTH-1:0] job_br,
  output logic             start,
  output logic [WIDTH-1:0] Data_AR,
  output logic [WIDTH-1:0] Data_BR,
  input  logic             done,
  input  logic [WIDTH-1:0] CR,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_timeout,
  output logic             res_mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] ar_q, ar_d, br_q, br_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_to_q, res_to_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] jc_q, jc_d;

`ifdef CR_JOB_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mis_q, mis_d;

  // Negative AR halves toward zero: bias by one before the arithmetic shift.
  function automatic logic [WIDTH-1:0] exp_f(input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] br);
    logic [WIDTH-1:0] t;
    t = ar + WIDTH'(1);
    if (ar[WIDTH-1])     return {t[WIDTH-1], t[WIDTH-1:1]};
    else if (ar != '0)   return br << 1;
    else                 return '0;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    ar_d        = ar_q;
    br_d        = br_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_to_d    = res_to_q;
    cnt_d       = cnt_q;
    jc_d        = jc_q;
`ifdef CR_JOB_CHECK_EN
    exp_d       = exp_q;
    mis_d       = mis_q;
`endif
    unique case (state_q)
      IDLE: if (job_valid) begin
        ar_d    = job_ar;
        br_d    = job_br;
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = REQ;
`ifdef CR_JOB_CHECK_EN
        exp_d   = exp_f(job_ar, job_br);
`endif
      end
      REQ, WAIT: begin
        if (state_q == REQ && !done) begin
          start_d = 1'b0;
          state_d = WAIT;
        end else if (state_q == WAIT && done) begin
          res_data_d  = CR;
          res_to_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef CR_JOB_CHECK_EN
          mis_d       = (CR != exp_q);
`endif
        end else if (cnt_q == T_LAST) begin
          // Normal exits above win over a timeout in the same cycle.
          start_d     = 1'b0;
          res_data_d  = '0;
          res_to_d    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef CR_JOB_CHECK_EN
          mis_d       = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        jc_d        = jc_q + CNT_W'(1);
        state_d     = IDLE;
`ifdef CR_JOB_CHECK_EN
        mis_d       = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      ar_q        <= '0;
      br_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_to_q    <= 1'b0;
      cnt_q       <= '0;
      jc_q        <= '0;
`ifdef CR_JOB_CHECK_EN
      exp_q       <= '0;
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      ar_q        <= ar_d;
      br_q        <= br_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_to_q    <= res_to_d;
      cnt_q       <= cnt_d;
      jc_q        <= jc_d;
`ifdef CR_JOB_CHECK_EN
      exp_q       <= exp_d;
      mis_q       <= mis_d;
`endif
    end
  end

  assign job_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign start       = start_q;
  assign Data_AR     = ar_q;
  assign Data_BR     = br_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign res_timeout = res_to_q;
  assign job_count   = jc_q;
`ifdef CR_JOB_CHECK_EN
  assign res_mismatch = mis_q;
`else
  assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cr_job_initiator.sv
// Bench for cr_job_initiator: directed protocol cases plus randomized jobs checked
// against a cycle-budget reference model of the timeout rules and result arithmetic.
module tb_cr_job_initiator;
  localparam int WIDTH = 16, TIMEOUT = 255, CNT_W = 8;

  logic             clk = 1'b0, reset_b = 1'b0;
  logic             job_valid = 1'b0, job_ready;
  logic [WIDTH-1:0] job_ar = '0, job_br = '0;
  logic             start;
  logic [WIDTH-1:0] Data_AR, Data_BR;
  logic             done = 1'b1;
  logic [WIDTH-1:0] CR = '0;
  logic             res_valid, res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_timeout, res_mismatch, busy;
  logic [CNT_W-1:0] job_count;

  int total = 0, bad = 0, mcount = 0;

  cr_job_initiator #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_b(reset_b), .job_valid(job_valid), .job_ready(job_ready),
    .job_ar(job_ar), .job_br(job_br), .start(start), .Data_AR(Data_AR), .Data_BR(Data_BR),
    .done(done), .CR(CR), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .res_mismatch(res_mismatch), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_exp(input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] br);
    int sa;
    sa = int'($signed(ar));
    if (sa > 0)      return 16'(int'(br) * 2);
    else if (sa < 0) return 16'(sa / 2);
    else             return '0;
  endfunction

  // a: edges after acceptance until done=0 is first sampled; b: further edges until done=1.
  task automatic do_job(input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] br,
                        input logic [WIDTH-1:0] cr, input int a, input int b, input int hold);
    int K;
    logic to, mis;
    logic [WIDTH-1:0] exp_data;
    if (a > TIMEOUT)              begin K = TIMEOUT;     to = 1'b1; end
    else if (a + b > TIMEOUT + 1) begin K = TIMEOUT + 1; to = 1'b1; end
    else                          begin K = a + b;       to = 1'b0; end
    exp_data = to ? '0 : cr;
`ifdef CR_JOB_CHECK_EN
    mis = !to && (cr != ref_exp(ar, br));
`else
    mis = 1'b0;
`endif
    job_ar = ar; job_br = br; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("acc_start", 32'(start), 32'd1);
    chk("acc_ar", 32'(Data_AR), 32'(ar));
    chk("acc_br", 32'(Data_BR), 32'(br));
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_ready", 32'(job_ready), 32'd0);
    for (int k = 1; k <= K; k++) begin
      done = (k < a) ? 1'b1 : ((k < a + b) ? 1'b0 : 1'b1);
      CR   = (k >= a + b) ? cr : 16'($urandom);
      tick();
      chk("start", 32'(start), 32'(k < a && k < K));
      chk("res_valid", 32'(res_valid), 32'(k == K));
    end
    chk("res_data", 32'(res_data), 32'(exp_data));
    chk("res_timeout", 32'(res_timeout), 32'(to));
    chk("res_mismatch", 32'(res_mismatch), 32'(mis));
    chk("count_hold", 32'(job_count), 32'(mcount % 256));
    CR = 16'($urandom);
    job_valid = 1'b1; job_ar = ~ar; job_br = ~br;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'(exp_data));
      chk("hold_to", 32'(res_timeout), 32'(to));
      chk("hold_ready", 32'(job_ready), 32'd0);
      chk("hold_ar", 32'(Data_AR), 32'(ar));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; job_valid = 1'b0; done = 1'b1;
    mcount++;
    chk("hs_valid", 32'(res_valid), 32'd0);
    chk("hs_mismatch", 32'(res_mismatch), 32'd0);
    chk("hs_count", 32'(job_count), 32'(mcount % 256));
    chk("hs_ready", 32'(job_ready), 32'd1);
    chk("hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ar, br, cr;
    tick(); tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_to", 32'(res_timeout), 32'd0);
    chk("rst_mis", 32'(res_mismatch), 32'd0);
    chk("rst_ar", 32'(Data_AR), 32'd0);
    chk("rst_br", 32'(Data_BR), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_count", 32'(job_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(job_ready), 32'd1);
    reset_b = 1'b1;
    tick();

    // Minimum latency job, then the -7 pair with matching and non-matching CR.
    do_job(16'h0004, 16'h0003, 16'h0006, 1, 1, 0);
    do_job(16'hFFF9, 16'h1234, 16'hFFFD, 1, 2, 1);
    do_job(16'hFFF9, 16'h1234, 16'hFFFC, 2, 1, 0);
    // done never acknowledges: timeout after TIMEOUT cycles of start.
    do_job(16'h0011, 16'h0022, 16'h0033, 1000, 1, 0);
    // Result stalled with a pending job; next job follows the handshake directly.
    do_job(16'h0100, 16'h0200, 16'h0400, 1, 3, 10);
    do_job(16'h7FFF, 16'h8001, 16'h0002, 1, 1, 0);

    // Async reset while waiting for done.
    job_ar = 16'h0042; job_br = 16'h0007; job_valid = 1'b1;
    tick();
    job_valid = 1'b0; done = 1'b0;
    tick();
    chk("wait_busy", 32'(busy), 32'd1);
    reset_b = 1'b0;
    #1;
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(job_count), 32'd0);
    chk("mid_rst_ar", 32'(Data_AR), 32'd0);
    tick();
    reset_b = 1'b1; done = 1'b1; mcount = 0;
    tick();
    do_job(16'h0005, 16'h0009, 16'h0012, 1, 1, 0);

    // Timeout edges: latest normal acknowledge/response versus one cycle later.
    do_job(16'h0001, 16'h0001, 16'h0002, TIMEOUT, 1, 0);
    do_job(16'h0001, 16'h0001, 16'h0002, TIMEOUT, 2, 0);
    do_job(16'h0001, 16'h0001, 16'h0002, TIMEOUT + 1, 1, 0);
    do_job(16'h8000, 16'h0000, 16'hC000, 3, TIMEOUT - 2, 0);

    while (mcount < 256) begin
      ar = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ar = '0;
      br = 16'($urandom);
      cr = $urandom_range(0, 1) ? ref_exp(ar, br) : 16'($urandom);
      do_job(ar, br, cr, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2));
    end
    chk("count_wrap", 32'(job_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cr_job_initiator.md
Name: cr_job_initiator

Overview:
- Initiator (host) end of the start/done operand protocol used by the AR/BR→CR control/datapath pair.
- Accepts operand jobs from upstream (valid/ready) and drives Data_AR/Data_BR plus start into the responder.
- Tracks done with a timeout, captures CR, and presents the result downstream (valid/ready).
- Sits between a job source (bench or sequencer) and the responder; counts completed jobs.

Parameters:
- WIDTH, 16, operand/result width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the job aborts; must be ≥ 2.
- CNT_W, 8, job_count width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_b  in  1  asynchronous, active-low reset.
- job_valid  in  1  upstream job offered.
- job_ready  out  1  initiator can accept a job.
- job_ar  in  WIDTH  AR operand (signed).
- job_br  in  WIDTH  BR operand (signed).
- start  out  1  start request to responder.
- Data_AR  out  WIDTH  AR operand to responder.
- Data_BR  out  WIDTH  BR operand to responder.
- done  in  1  responder done level.
- CR  in  WIDTH  responder result (signed).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  WIDTH  captured CR, or 0 on timeout.
- res_timeout  out  1  qualifies res_data: job aborted.
- res_mismatch  out  1  checker flag (see Optional Feature).
- busy  out  1  state != IDLE.
- job_count  out  CNT_W  completed (delivered) jobs, wraps.

Behaviour:
- Reset (async, reset_b=0): state=IDLE; start, res_valid, res_timeout, res_mismatch=0; Data_AR, Data_BR, res_data, job_count=0; timeout counter=0. Reset mid-job drops start immediately, and the job and any pending result are lost.
- All outputs are registered except job_ready=(state==IDLE) and busy.
- Protocol with responder:
  - done is a level and is stale-high from the previous job.
  - The responder acknowledges start by dropping done, then raises done when CR is valid.
  - CR is sampled only in WAIT with done=1.
- FSM:
  - IDLE: on job_valid&job_ready, latch job_ar→Data_AR and job_br→Data_BR, set start=1, clear counter, go to REQ (start is visible the cycle after acceptance).
  - REQ: start held 1. If done=0 is sampled, set start=0 and go to WAIT. Else increment counter.
  - WAIT: if done=1, res_data←CR, res_timeout←0, res_valid←1, go to HOLD. Else increment counter.
  - Timeout (REQ or WAIT): when counter reaches TIMEOUT-1 without the exit condition, set start=0, res_data←0, res_timeout←1, res_valid←1, go to HOLD. A normal exit in the same cycle takes priority over timeout.
  - HOLD: res_valid, res_data and res_timeout stay stable until res_ready=1. On handshake, res_valid←0, job_count←job_count+1 (mod 2^CNT_W, timeouts included), go to IDLE.
- Data_AR and Data_BR stay stable from acceptance until the next job is accepted.
- Back-to-back: the earliest next acceptance is the cycle after the HOLD handshake. There is no overlap of jobs.
- job_valid is ignored outside IDLE. res_ready is ignored outside HOLD.
- Minimum latency, acceptance to res_valid: 3 cycles (accept, REQ with done dropping, WAIT with done=1).

Optional Feature:
- Macro CR_JOB_CHECK_EN.
- Defined:
  - At acceptance, compute the expected result into a register:
    - AR>0 → BR*2 (low WIDTH bits).
    - AR<0 → AR/2, truncating toward zero.
    - AR==0 → 0.
  - On normal capture, res_mismatch←(CR != expected).
  - On timeout, res_mismatch←0.
  - res_mismatch is cleared with res_valid.
- Undefined: no expected register; res_mismatch tied 0.

Test Plan:
- Job AR=0x0004, BR=0x0003; responder drops done 1 cycle after start, raises it 1 cycle later with CR=0x0006 → res_valid after 3 cycles, res_data=0x0006, res_timeout=0, res_mismatch=0, job_count=1 after res_ready.
- AR=0xFFF9 (-7), BR=0x1234, CR=0xFFFD → res_data=0xFFFD. With CR_JOB_CHECK_EN: res_mismatch=0. Repeat with CR=0xFFFC → res_mismatch=1.
- done stuck at 1 (no acknowledge), TIMEOUT=255 → start high exactly 255 cycles then 0; res_valid with res_timeout=1, res_data=0x0000.
- res_ready held 0 for 10 cycles with job_valid=1 and a second job pending → res_valid and res_data stable, job_ready=0, second job accepted the cycle after the handshake.
- reset_b pulsed low during WAIT → start, res_valid and busy go to 0 immediately, job_count=0; the next job completes normally.
- 256 jobs with CNT_W=8 → job_count returns to 0x00.
